// File: rtl/cnn_pkg.sv
// Shared constants and FSM encoding for the batch CNN sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cnn_pkg;

  localparam int MAX_IMG    = 250;    // images held by the batch memories
  localparam int IMG_STRIDE = 28*28;  // input pixels per image
  localparam int OUT_STRIDE = 10;     // output logits per image (classes)

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2
  } state_t;

endpackage

// File: rtl/stride_base_acc.sv
// Per-address-space base register: load start*STRIDE, then add STRIDE per step.
// Latency: base valid the cycle after load/step.
// Backpressure: none; load takes priority over step.
module stride_base_acc #(
  parameter int STRIDE = 784,
  parameter int IDX_W  = 8,
  parameter int BW     = 18
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             load,
  input  logic [IDX_W-1:0] load_idx,
  input  logic             step,
  output logic [BW-1:0]    base
);

  localparam logic [BW-1:0] STRIDE_V = BW'(STRIDE);

  // Constant-coefficient product only at load; per-image advance is a plain add.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      base <= '0;
    end else if (load) begin
      base <= BW'(load_idx) * STRIDE_V;
    end else if (step) begin
      base <= base + STRIDE_V;
    end
  end

endmodule

// File: rtl/batch_img_seq.sv
// Batch sequencer: launches one pipeline inference per image of a window, offsets local addresses.
// Latency: outer_start->inner_start 2 cycles; inner_done->next inner_start 2; inner_done->outer_done 1.
// Backpressure: outer_start ignored while busy; inner_done honoured only in WAIT; abort wins.
module batch_img_seq
  import cnn_pkg::*;
#(
  parameter int MAX_IMG_P    = cnn_pkg::MAX_IMG,
  parameter int IMG_STRIDE_P = cnn_pkg::IMG_STRIDE,
  parameter int OUT_STRIDE_P = cnn_pkg::OUT_STRIDE,
  parameter int IN_AW        = 10,
  parameter int OUT_AW       = 4,
  parameter int IDX_W        = $clog2(MAX_IMG_P + 1),
  parameter int IMG_BW       = $clog2(MAX_IMG_P * IMG_STRIDE_P),
  parameter int OUT_BW       = $clog2(MAX_IMG_P * OUT_STRIDE_P)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              outer_start,
  input  logic [IDX_W-1:0]  start_img,
  input  logic [IDX_W-1:0]  img_count,
  input  logic              abort,
  input  logic              inner_done,
  input  logic [IN_AW-1:0]  c1_imem_addrb,
  input  logic [OUT_AW-1:0] fc_omem_addra,
  output logic              inner_start,
  output logic              outer_done,
  output logic              aborted,
  output logic              cfg_err,
  output logic              busy,
  output logic [IDX_W-1:0]  img_idx,
  output logic [IMG_BW-1:0] c1_imem_addrb_cnted,
  output logic [OUT_BW-1:0] fc_omem_addra_cnted
);

  localparam logic [IDX_W:0]   MAX_V = (IDX_W+1)'(MAX_IMG_P);
  localparam logic [IDX_W-1:0] ONE_V = IDX_W'(1);

  state_t             state;
  logic [IDX_W-1:0]   remaining;
  logic [IDX_W:0]     end_idx;
  logic               start_ok;
  logic               base_load;
  logic               base_step;
  logic [IMG_BW-1:0]  in_base;
  logic [OUT_BW-1:0]  out_base;

  // One extra bit so start+count cannot wrap before the capacity compare.
  assign end_idx  = {1'b0, start_img} + {1'b0, img_count};
  assign start_ok = (img_count != '0) && (end_idx <= MAX_V);

  assign base_load = (state == ST_IDLE) && outer_start && start_ok;
  assign base_step = (state == ST_WAIT) && !abort && inner_done && (remaining != ONE_V);

  assign busy = (state != ST_IDLE);

  // Sequencer FSM with registered single-cycle status pulses.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= ST_IDLE;
      remaining   <= '0;
      img_idx     <= '0;
      inner_start <= 1'b0;
      outer_done  <= 1'b0;
      aborted     <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      inner_start <= 1'b0;
      outer_done  <= 1'b0;
      aborted     <= 1'b0;
      cfg_err     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (outer_start) begin
            if (start_ok) begin
              state     <= ST_LAUNCH;
              remaining <= img_count;
              img_idx   <= start_img;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        ST_LAUNCH: begin
          if (abort) begin
            state   <= ST_IDLE;
            aborted <= 1'b1;
          end else begin
            state       <= ST_WAIT;
            inner_start <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (abort) begin
            state   <= ST_IDLE;
            aborted <= 1'b1;
          end else if (inner_done) begin
            if (remaining == ONE_V) begin
              state      <= ST_IDLE;
              outer_done <= 1'b1;
            end else begin
              state     <= ST_LAUNCH;
              remaining <= remaining - ONE_V;
              img_idx   <= img_idx + ONE_V;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  stride_base_acc #(
    .STRIDE (IMG_STRIDE_P),
    .IDX_W  (IDX_W),
    .BW     (IMG_BW)
  ) u_in_base (
    .clk      (clk),
    .resetn   (resetn),
    .load     (base_load),
    .load_idx (start_img),
    .step     (base_step),
    .base     (in_base)
  );

  stride_base_acc #(
    .STRIDE (OUT_STRIDE_P),
    .IDX_W  (IDX_W),
    .BW     (OUT_BW)
  ) u_out_base (
    .clk      (clk),
    .resetn   (resetn),
    .load     (base_load),
    .load_idx (start_img),
    .step     (base_step),
    .base     (out_base)
  );

  // Local addresses are offset into the batch memories; results wrap at the output width.
  assign c1_imem_addrb_cnted = in_base + IMG_BW'(c1_imem_addrb);
  assign fc_omem_addra_cnted = out_base + OUT_BW'(fc_omem_addra);

endmodule

// File: tb/tb_batch_img_seq.sv
// Directed bench for batch_img_seq with hand-computed expected values.
// Latency: checks 2-cycle launch and 1-cycle completion timing.
// Backpressure: exercises ignored starts, spurious done, abort and reset.
module tb_batch_img_seq;

  localparam int IDX_W  = 8;
  localparam int IMG_BW = 18;
  localparam int OUT_BW = 12;

  logic              clk = 1'b0;
  logic              resetn;
  logic              outer_start;
  logic [IDX_W-1:0]  start_img;
  logic [IDX_W-1:0]  img_count;
  logic              abort;
  logic              inner_done;
  logic [9:0]        c1_imem_addrb;
  logic [3:0]        fc_omem_addra;
  logic              inner_start;
  logic              outer_done;
  logic              aborted;
  logic              cfg_err;
  logic              busy;
  logic [IDX_W-1:0]  img_idx;
  logic [IMG_BW-1:0] c1_imem_addrb_cnted;
  logic [OUT_BW-1:0] fc_omem_addra_cnted;

  int n_chk  = 0;
  int n_pass = 0;
  int is_cnt = 0;
  int od_cnt = 0;
  int ab_cnt = 0;
  int ce_cnt = 0;

  batch_img_seq dut (
    .clk                 (clk),
    .resetn              (resetn),
    .outer_start         (outer_start),
    .start_img           (start_img),
    .img_count           (img_count),
    .abort               (abort),
    .inner_done          (inner_done),
    .c1_imem_addrb       (c1_imem_addrb),
    .fc_omem_addra       (fc_omem_addra),
    .inner_start         (inner_start),
    .outer_done          (outer_done),
    .aborted             (aborted),
    .cfg_err             (cfg_err),
    .busy                (busy),
    .img_idx             (img_idx),
    .c1_imem_addrb_cnted (c1_imem_addrb_cnted),
    .fc_omem_addra_cnted (fc_omem_addra_cnted)
  );

  always #5 clk = ~clk;

  // Pulse counters: each pulse lives for exactly one cycle, so one posedge sees it once.
  always @(posedge clk) begin
    if (inner_start) is_cnt++;
    if (outer_done)  od_cnt++;
    if (aborted)     ab_cnt++;
    if (cfg_err)     ce_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Runs one batch; abort_at = image index whose WAIT gets abort+inner_done,
  // poke_at = image index whose WAIT sees a stray outer_start (-1 disables either).
  task automatic run_batch(input int s, input int n, input int abort_at, input int poke_at);
    int b_is, b_od, b_ab, b_ce;
    b_is = is_cnt; b_od = od_cnt; b_ab = ab_cnt; b_ce = ce_cnt;
    start_img = IDX_W'(s); img_count = IDX_W'(n); outer_start = 1'b1;
    @(negedge clk);
    outer_start = 1'b0;
    for (int i = 0; i < n; i++) begin
      chk("launch_gap", 32'(inner_start), 0);
      chk("busy_launch", 32'(busy), 1);
      @(negedge clk);
      chk("inner_start", 32'(inner_start), 1);
      chk("img_idx", 32'(img_idx), s + i);
      c1_imem_addrb = 10'd0; fc_omem_addra = 4'd9;
      #1;
      chk("in_addr0", 32'(c1_imem_addrb_cnted), (s + i) * 784);
      chk("out_addr9", 32'(fc_omem_addra_cnted), (s + i) * 10 + 9);
      c1_imem_addrb = 10'd783;
      #1;
      chk("in_addr783", 32'(c1_imem_addrb_cnted), (s + i) * 784 + 783);
      @(negedge clk);
      chk("start_pulse_end", 32'(inner_start), 0);
      if (i == poke_at) begin
        start_img = 8'd0; img_count = 8'd0; outer_start = 1'b1;
        @(negedge clk);
        outer_start = 1'b0;
        chk("poke_no_cfg_err", 32'(cfg_err), 0);
        chk("poke_idx_hold", 32'(img_idx), s + i);
        @(negedge clk);
      end else begin
        repeat (2) @(negedge clk);
      end
      if (i == abort_at) begin
        abort = 1'b1; inner_done = 1'b1;
        @(negedge clk);
        abort = 1'b0; inner_done = 1'b0;
        chk("aborted", 32'(aborted), 1);
        chk("busy_after_abort", 32'(busy), 0);
        chk("no_done_on_abort", 32'(outer_done), 0);
        repeat (4) @(negedge clk);
        chk("abort_starts", 32'(is_cnt - b_is), abort_at + 1);
        chk("abort_no_outer_done", 32'(od_cnt - b_od), 0);
        chk("abort_count", 32'(ab_cnt - b_ab), 1);
        return;
      end
      inner_done = 1'b1;
      @(negedge clk);
      inner_done = 1'b0;
      if (i == n - 1) begin
        chk("outer_done", 32'(outer_done), 1);
        chk("busy_done", 32'(busy), 0);
        chk("idx_final", 32'(img_idx), s + n - 1);
      end
    end
    @(negedge clk);
    chk("outer_done_pulse_end", 32'(outer_done), 0);
    @(negedge clk);
    chk("n_inner_start", 32'(is_cnt - b_is), n);
    chk("n_outer_done", 32'(od_cnt - b_od), 1);
    chk("no_cfg_err", 32'(ce_cnt - b_ce), 0);
  endtask

  task automatic bad_start(input int s, input int n);
    int b_is, b_ce;
    b_is = is_cnt; b_ce = ce_cnt;
    start_img = IDX_W'(s); img_count = IDX_W'(n); outer_start = 1'b1;
    @(negedge clk);
    outer_start = 1'b0;
    chk("cfg_err", 32'(cfg_err), 1);
    chk("cfg_busy", 32'(busy), 0);
    @(negedge clk);
    chk("cfg_err_end", 32'(cfg_err), 0);
    repeat (3) @(negedge clk);
    chk("cfg_no_start", 32'(is_cnt - b_is), 0);
    chk("cfg_err_once", 32'(ce_cnt - b_ce), 1);
  endtask

  initial begin
    resetn = 1'b0; outer_start = 1'b0; start_img = '0; img_count = '0;
    abort = 1'b0; inner_done = 1'b0; c1_imem_addrb = '0; fc_omem_addra = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_idx", 32'(img_idx), 0);
    chk("rst_inner_start", 32'(inner_start), 0);
    chk("rst_in_addr", 32'(c1_imem_addrb_cnted), 0);
    chk("rst_out_addr", 32'(fc_omem_addra_cnted), 0);
    resetn = 1'b1;
    @(negedge clk);

    run_batch(0, 1, -1, -1);      // single image
    run_batch(3, 4, -1, -1);      // window 3..6
    run_batch(0, 250, -1, -1);    // full capacity
    bad_start(0, 0);              // empty batch
    bad_start(248, 5);            // overruns capacity
    run_batch(245, 5, -1, -1);    // exactly reaches capacity
    run_batch(1, 5, 2, -1);       // abort in third WAIT with coincident inner_done
    run_batch(7, 2, -1, -1);      // normal run after abort
    run_batch(20, 3, -1, 1);      // stray outer_start mid-batch

    // Spurious inner_done while idle.
    begin
      int b_is;
      b_is = is_cnt;
      inner_done = 1'b1;
      @(negedge clk);
      inner_done = 1'b0;
      chk("spur_busy", 32'(busy), 0);
      repeat (3) @(negedge clk);
      chk("spur_no_start", 32'(is_cnt - b_is), 0);
    end

    // Reset mid-batch.
    begin
      int b_od;
      b_od = od_cnt;
      start_img = 8'd5; img_count = 8'd3; outer_start = 1'b1;
      @(negedge clk);
      outer_start = 1'b0;
      repeat (3) @(negedge clk);
      chk("pre_rst_busy", 32'(busy), 1);
      resetn = 1'b0;
      c1_imem_addrb = '0; fc_omem_addra = '0;
      #1;
      chk("mid_rst_busy", 32'(busy), 0);
      chk("mid_rst_idx", 32'(img_idx), 0);
      chk("mid_rst_in_addr", 32'(c1_imem_addrb_cnted), 0);
      chk("mid_rst_out_addr", 32'(fc_omem_addra_cnted), 0);
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      chk("mid_rst_no_done", 32'(od_cnt - b_od), 0);
    end
    run_batch(10, 2, -1, -1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
